// File: rtl/cordic_req_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cordic_req_scheduler_pkg
//  Purpose  : Angle-format constants, engine seeds and small helpers shared
//             by the CORDIC request scheduler and its tag FIFO.
//  Revision : 1.0  initial release
// ============================================================================
package cordic_req_scheduler_pkg;

  // Angle format: signed, 12 fractional bits.
  localparam int c_DATA_WIDTH = 18;
  localparam int c_FRAC_BITS  = 12;

  localparam logic [17:0] c_PI_2   = 18'h01922;
  localparam logic [17:0] c_PI     = 18'h03244;
  localparam logic [17:0] c_3PI_2  = 18'h04B66;
  localparam logic [17:0] c_TWO_PI = 18'h06488;

  // Engine seeds: gain-compensated x start value and atan(2^0).
  localparam logic [17:0] c_X_INIT = 18'h009B7;
  localparam logic [17:0] c_ATAN0  = 18'h00C91;

  // Credit counter update selected each cycle.
  typedef enum logic [1:0] {
    CRED_HOLD = 2'd0,
    CRED_INC  = 2'd1,
    CRED_DEC  = 2'd2
  } cred_op_e;

  // (base + off) modulo n, valid for base < n and off <= n.
  function automatic int f_wrap(input int base, input int off, input int n);
    int s;
    s = base + off;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_req_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : cordic_req_scheduler_if
//  Purpose  : Requester, engine and response signals of the CORDIC request
//             scheduler. The scheduler uses the slave view; the client side
//             (requesters plus engine) uses the master view.
//  Revision : 1.0  initial release
// ============================================================================
interface cordic_req_scheduler_if
  import cordic_req_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH = c_DATA_WIDTH,
  parameter int N_REQ      = 4
);
  localparam int c_ID_W = $clog2(N_REQ);

  // Requester side
  logic [N_REQ-1:0]            i_req_valid;
  logic [N_REQ*DATA_WIDTH-1:0] i_req_alpha;
  logic [N_REQ-1:0]            o_req_ready;

  // Engine side
  logic [DATA_WIDTH-1:0]       o_eng_x;
  logic [DATA_WIDTH-1:0]       o_eng_y;
  logic [DATA_WIDTH-1:0]       o_eng_alpha;
  logic [DATA_WIDTH-1:0]       o_eng_atan0;
  logic                        o_eng_valid;
  logic [DATA_WIDTH-1:0]       i_eng_cos;
  logic [DATA_WIDTH-1:0]       i_eng_sin;
  logic                        i_eng_valid;

  // Response and status
  logic                        o_rsp_valid;
  logic [c_ID_W-1:0]           o_rsp_id;
  logic [DATA_WIDTH-1:0]       o_rsp_cos;
  logic [DATA_WIDTH-1:0]       o_rsp_sin;
  logic                        o_busy;
  logic                        o_orphan;

  modport slave (
    input  i_req_valid, i_req_alpha, i_eng_cos, i_eng_sin, i_eng_valid,
    output o_req_ready, o_eng_x, o_eng_y, o_eng_alpha, o_eng_atan0, o_eng_valid,
    output o_rsp_valid, o_rsp_id, o_rsp_cos, o_rsp_sin, o_busy, o_orphan
  );

  modport master (
    output i_req_valid, i_req_alpha, i_eng_cos, i_eng_sin, i_eng_valid,
    input  o_req_ready, o_eng_x, o_eng_y, o_eng_alpha, o_eng_atan0, o_eng_valid,
    input  o_rsp_valid, o_rsp_id, o_rsp_cos, o_rsp_sin, o_busy, o_orphan
  );

endinterface
`default_nettype wire

// File: rtl/cordic_tag_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : cordic_tag_fifo
//  Purpose  : Synchronous FIFO holding requester ids of ops in flight.
//             Full/empty are registered; a push is refused while full and a
//             pop is refused while empty, judged on the registered flags.
//  Revision : 1.0  initial release
// ============================================================================
module cordic_tag_fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 2
) (
  input  wire              i_clk,
  input  wire              i_rst,
  input  wire              i_push,
  input  wire [WIDTH-1:0]  i_din,
  input  wire              i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic [c_CNT_W-1:0] w_count_nxt;
  logic               r_full;
  logic               r_empty;
  logic               w_do_push;
  logic               w_do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [c_PTR_W-1:0] f_ptr_inc(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
  endfunction

  assign w_do_push = i_push && !r_full;
  assign w_do_pop  = i_pop  && !r_empty;

  // Occupancy after this cycle's accepted push/pop.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_do_push, w_do_pop})
      2'b10:   w_count_nxt = r_count + c_CNT_W'(1);
      2'b01:   w_count_nxt = r_count - c_CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointer, occupancy and flag registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_do_push) r_wr_ptr <= f_ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= f_ptr_inc(r_rd_ptr);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == c_CNT_W'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule
`default_nettype wire

// File: rtl/cordic_req_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : cordic_req_scheduler
//  Purpose  : Shares one pipelined CORDIC sin/cos engine among N_REQ
//             requesters: round-robin grant, range reduction into
//             [0, 2*pi), credit-limited issue and in-order tagged returns.
//  Revision : 1.0  initial release
// ============================================================================
module cordic_req_scheduler
  import cordic_req_scheduler_pkg::*;
#(
  parameter int                    DATA_WIDTH   = c_DATA_WIDTH,
  parameter int                    N_REQ        = 4,
  parameter int                    MAX_INFLIGHT = 32,
  parameter logic [DATA_WIDTH-1:0] X_INIT       = c_X_INIT,
  parameter logic [DATA_WIDTH-1:0] ATAN0        = c_ATAN0,
  parameter logic [DATA_WIDTH-1:0] TWO_PI       = c_TWO_PI
) (
  input wire                    i_clk,
  input wire                    i_rst,
  cordic_req_scheduler_if.slave bus
);

  localparam int c_ID_W   = $clog2(N_REQ);
  localparam int c_CRED_W = $clog2(MAX_INFLIGHT + 1);

  // Arbitration
  logic [DATA_WIDTH-1:0] w_alpha_arr [N_REQ];
  logic [c_ID_W-1:0]     r_rr_ptr;
  logic [c_ID_W-1:0]     w_scan;
  logic [c_ID_W-1:0]     w_grant_id;
  logic                  w_grant_any;
  logic                  w_can_grant;
  logic                  w_accept;
  logic [N_REQ-1:0]      w_ready;
  logic [c_CRED_W:0]     w_committed;

  // Reduction and issue
  logic [DATA_WIDTH:0]   w_a_ext;
  logic [DATA_WIDTH:0]   w_two_pi_ext;
  logic [DATA_WIDTH:0]   w_red_ext;
  logic                  r_issue_valid;
  logic [DATA_WIDTH-1:0] r_issue_alpha;
  logic [c_ID_W-1:0]     r_issue_id;

  // Credits, tags and responses
  logic [c_CRED_W-1:0]   r_credits;
  cred_op_e              w_cred_op;
  logic [c_ID_W-1:0]     w_tag_head;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic                  w_ret;
  logic                  w_orphan_evt;
  logic                  r_rsp_valid;
  logic [c_ID_W-1:0]     r_rsp_id;
  logic [DATA_WIDTH-1:0] r_rsp_cos;
  logic [DATA_WIDTH-1:0] r_rsp_sin;
  logic                  r_orphan;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign w_alpha_arr[gi] = bus.i_req_alpha[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // The op accepted last cycle is not yet in r_credits, so it is counted
  // here to keep the credit limit exact under back-to-back grants.
  assign w_committed = {1'b0, r_credits} + {{c_CRED_W{1'b0}}, r_issue_valid};
  assign w_can_grant = (w_committed < (c_CRED_W+1)'(MAX_INFLIGHT)) && !w_fifo_full;

  // Round-robin search from r_rr_ptr; scanning downwards lets the nearest
  // valid requester overwrite farther ones.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_id  = '0;
    w_scan      = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_scan = c_ID_W'(f_wrap(int'(r_rr_ptr), k, N_REQ));
      if (bus.i_req_valid[w_scan]) begin
        w_grant_any = 1'b1;
        w_grant_id  = w_scan;
      end
    end
  end

  assign w_accept = w_grant_any && w_can_grant;

  // One-hot ready for the granted requester only.
  always_comb begin
    w_ready = '0;
    if (w_accept) w_ready[w_grant_id] = 1'b1;
  end

  // Single-step range reduction in DATA_WIDTH+1 bits.
  always_comb begin
    w_a_ext      = {w_alpha_arr[w_grant_id][DATA_WIDTH-1], w_alpha_arr[w_grant_id]};
    w_two_pi_ext = {1'b0, TWO_PI};
    w_red_ext    = w_a_ext;
    if (w_a_ext[DATA_WIDTH])
      w_red_ext = w_a_ext + w_two_pi_ext;
    else if (w_a_ext >= w_two_pi_ext)
      w_red_ext = w_a_ext - w_two_pi_ext;
  end

  // Round-robin pointer moves to the requester after the last grant.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)         r_rr_ptr <= '0;
    else if (w_accept) r_rr_ptr <= c_ID_W'(f_wrap(int'(w_grant_id), 1, N_REQ));
  end

  // Issue register: engine strobe one cycle after the handshake.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_issue_valid <= 1'b0;
      r_issue_alpha <= '0;
      r_issue_id    <= '0;
    end else begin
      r_issue_valid <= w_accept;
      if (w_accept) begin
        r_issue_alpha <= w_red_ext[DATA_WIDTH-1:0];
        r_issue_id    <= w_grant_id;
      end
    end
  end

  cordic_tag_fifo #(
    .DEPTH (MAX_INFLIGHT),
    .WIDTH (c_ID_W)
  ) u_tag_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (r_issue_valid),
    .i_din   (r_issue_id),
    .i_pop   (w_ret),
    .o_dout  (w_tag_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // A return with no tag (e.g. draining after a reset) is an orphan.
  assign w_ret        = bus.i_eng_valid && !w_fifo_empty;
  assign w_orphan_evt = bus.i_eng_valid &&  w_fifo_empty;

  // Credit update: issue adds, tagged return removes, both cancel.
  always_comb begin
    w_cred_op = CRED_HOLD;
    if (r_issue_valid && !w_ret)      w_cred_op = CRED_INC;
    else if (!r_issue_valid && w_ret) w_cred_op = CRED_DEC;
  end

  // Credit counter register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_credits <= '0;
    end else begin
      case (w_cred_op)
        CRED_INC: r_credits <= r_credits + c_CRED_W'(1);
        CRED_DEC: r_credits <= r_credits - c_CRED_W'(1);
        default:  r_credits <= r_credits;
      endcase
    end
  end

  // Response register and sticky orphan flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_cos   <= '0;
      r_rsp_sin   <= '0;
      r_orphan    <= 1'b0;
    end else begin
      r_rsp_valid <= w_ret;
      if (w_ret) begin
        r_rsp_id  <= w_tag_head;
        r_rsp_cos <= bus.i_eng_cos;
        r_rsp_sin <= bus.i_eng_sin;
      end
      if (w_orphan_evt) r_orphan <= 1'b1;
    end
  end

  assign bus.o_req_ready = w_ready;
  assign bus.o_eng_x     = X_INIT;
  assign bus.o_eng_y     = '0;
  assign bus.o_eng_alpha = r_issue_alpha;
  assign bus.o_eng_atan0 = ATAN0;
  assign bus.o_eng_valid = r_issue_valid;
  assign bus.o_rsp_valid = r_rsp_valid;
  assign bus.o_rsp_id    = r_rsp_id;
  assign bus.o_rsp_cos   = r_rsp_cos;
  assign bus.o_rsp_sin   = r_rsp_sin;
  assign bus.o_busy      = (r_credits != '0);
  assign bus.o_orphan    = r_orphan;

endmodule
`default_nettype wire
